// File: rtl/button_event_ctrl.sv
// Multi-channel push-button controller: one shared tick prescaler and a
// round-robin scan debounce all channels into a 4-deep event FIFO.

module button_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge i_clk)
    if (i_rst) {q, s1} <= {2{RST_VAL}};
    else       {q, s1} <= {s1, d};
endmodule

module button_event_ctrl #(
  parameter int NUM_SW      = 4,
  parameter int TICK_DIV    = 25000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_SW-1:0] i_switch,
  input  logic              i_ovf_clr,
  input  logic              i_evt_ready,
  output logic [NUM_SW-1:0] o_switch,
  output logic              o_evt_valid,
  output logic [2:0]        o_evt_id,
  output logic [1:0]        o_evt_type,
  output logic              o_overflow
);
  localparam int IW    = $clog2(NUM_SW);
  localparam int PW    = $clog2(TICK_DIV);
  localparam int STW   = $clog2(DEBOUNCE_MS + 1);
  localparam int HW    = $clog2(LONG_MS + 1);
  localparam int DEPTH = 4;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2
  } evt_type_e;

  typedef struct packed {
    logic [2:0] id;
    evt_type_e  typ;
  } evt_t;

  typedef enum logic {S_IDLE, S_SCAN} state_e;

  // Per-channel synchronisers; idle level is released (1)
  logic [NUM_SW-1:0] raw;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sync
    button_sync #(.RST_VAL(1'b1)) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .d     (i_switch[g]),
      .q     (raw[g])
    );
  end

  logic [PW-1:0] pre_cnt;
  logic          tick;

  always_ff @(posedge i_clk)
    if (i_rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (pre_cnt == PW'(TICK_DIV - 1));
      pre_cnt <= (pre_cnt == PW'(TICK_DIV - 1)) ? '0 : pre_cnt + 1'b1;
    end

  state_e        state, state_nx;
  logic [IW-1:0] idx, idx_nx;

  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      S_IDLE: if (tick) begin
        state_nx = S_SCAN;
        idx_nx   = '0;
      end
      S_SCAN: begin
        if (idx == IW'(NUM_SW - 1)) state_nx = S_IDLE;
        else                        idx_nx   = idx + 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  logic [NUM_SW-1:0][STW-1:0] stable;
  logic [NUM_SW-1:0][HW-1:0]  hold;
  logic [NUM_SW-1:0]          ldone;

  logic           scan, cur_raw, cur_lvl, chg, hit_db, hold_en, hit_long, push;
  logic [STW-1:0] st_inc;
  logic [HW-1:0]  hd_inc;
  evt_t           push_evt;

  // Update for the one channel under the scan pointer this cycle
  always_comb begin
    scan         = (state == S_SCAN);
    cur_raw      = raw[idx];
    cur_lvl      = o_switch[idx];
    st_inc       = stable[idx] + 1'b1;
    hd_inc       = hold[idx] + 1'b1;
    chg          = (cur_raw != cur_lvl);
    hit_db       = chg && (st_inc == STW'(DEBOUNCE_MS));
    hold_en      = !hit_db && !cur_lvl && !ldone[idx];
    hit_long     = hold_en && (hd_inc == HW'(LONG_MS));
    push         = scan && (hit_db || hit_long);
    push_evt.id  = 3'(idx);
    push_evt.typ = hit_db ? (cur_raw ? EVT_RELEASE : EVT_PRESS) : EVT_LONG;
  end

  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_switch <= '1;
      stable   <= '0;
      hold     <= '0;
      ldone    <= '0;
    end else if (scan) begin
      if (hit_db) begin
        o_switch[idx] <= cur_raw;
        stable[idx]   <= '0;
        if (cur_raw) begin
          hold[idx]  <= '0;
          ldone[idx] <= 1'b0;
        end
      end else if (chg) begin
        stable[idx] <= st_inc;
      end else begin
        stable[idx] <= '0;
      end
      // ldone gates further counting, so hold saturates at LONG_MS
      if (hold_en) begin
        hold[idx] <= hd_inc;
        if (hit_long) ldone[idx] <= 1'b1;
      end
    end

  evt_t       mem [DEPTH];
  evt_t       head;
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       full, pop, push_ok;

  assign full        = (count == 3'(DEPTH));
  assign o_evt_valid = (count != 3'd0);
  assign pop         = o_evt_valid && i_evt_ready;
  assign push_ok     = push && (!full || pop);
  assign head        = mem[rd_ptr];
  assign o_evt_id    = head.id;
  assign o_evt_type  = head.typ;

  always_ff @(posedge i_clk)
    if (push_ok) mem[wr_ptr] <= push_evt;

  always_ff @(posedge i_clk)
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + 3'(push_ok) - 3'(pop);
      // A drop in the same cycle as a clear keeps the flag set
      if (push && full && !pop) o_overflow <= 1'b1;
      else if (i_ovf_clr)       o_overflow <= 1'b0;
    end
endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Multi-channel switch controller for the board's push-buttons and encoder push-switch.
- One shared 1 ms tick prescaler and one round-robin scan sequencer debounce all channels, instead of one wait counter per switch.
- Produces debounced levels plus press/release/long-press events, queued in a 4-deep FIFO behind a valid/ready interface for the user logic.

Parameters:
- NUM_SW, 4, number of switch channels (2..8).
- TICK_DIV, 25000, i_clk cycles per tick (1 ms at 25 MHz); must exceed NUM_SW+1.
- DEBOUNCE_MS, 10, consecutive ticks raw must differ from debounced level before it is accepted (>=2).
- LONG_MS, 1000, ticks a channel must stay debounced-pressed before a LONG event (>DEBOUNCE_MS).

Ports:
- i_clk  in  1  system clock, 25 MHz.
- i_rst  in  1  synchronous, active-high reset.
- i_switch  in  NUM_SW  raw switch inputs, asynchronous, active-low (idle 1).
- i_ovf_clr  in  1  clears o_overflow.
- i_evt_ready  in  1  consumer accepts head event.
- o_switch  out  NUM_SW  debounced levels, active-low.
- o_evt_valid  out  1  FIFO head valid.
- o_evt_id  out  3  channel index of head event.
- o_evt_type  out  2  0=PRESS, 1=RELEASE, 2=LONG (3 unused).
- o_overflow  out  1  sticky event-dropped flag.

Behaviour:
- Reset (i_rst=1 at a clk edge): o_switch all 1, sync flops all 1, per-channel stable/hold counters 0, long-done flags 0, prescaler 0, sequencer IDLE, FIFO empty, o_evt_valid 0, o_overflow 0. Reset mid-scan or mid-debounce abandons all progress; no event is emitted.
- Synchroniser: 2-flop per channel; the sampled raw value is the second flop.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - A one-cycle tick pulse fires when the count wraps to 0.
- Sequencer FSM, IDLE -> SCAN -> IDLE:
  - On tick: enter SCAN with idx=0.
  - SCAN processes channel idx in one cycle, then idx+1; after idx=NUM_SW-1 it returns to IDLE.
  - A scan takes exactly NUM_SW cycles; a tick arriving during SCAN cannot occur because of the TICK_DIV constraint.
- Per-channel update in its scan cycle, evaluated in this priority:
  - raw != o_switch[idx]: stable++. If the new value == DEBOUNCE_MS: o_switch[idx]<=raw, stable<=0, push PRESS (raw=0) or RELEASE (raw=1). A release also clears hold and long-done.
  - raw == o_switch[idx]: stable<=0 (a glitch restarts the count).
  - Long-press check applies only when no transition occurred this scan, o_switch[idx]=0 and long-done=0: hold++. When hold reaches LONG_MS, push LONG and set long-done. Hold saturates; exactly one LONG per press.
  - At most one event per channel per scan.
- Latency:
  - A raw edge held stable reaches o_switch DEBOUNCE_MS ticks after first being sampled at a scan, plus 2 sync cycles.
  - The event is in the FIFO on the clock after the channel's scan cycle.
  - o_evt_valid rises that same edge if the FIFO was empty (first-word-fall-through).
- FIFO, depth 4:
  - Head drives o_evt_id/o_evt_type; these are held stable while o_evt_valid=1 and i_evt_ready=0.
  - Pop on valid & ready.
  - Push and pop in the same cycle are both honoured, including when full (count unchanged).
  - Push when full with no pop: event dropped, o_overflow<=1.
  - o_overflow stays 1 until i_ovf_clr=1 or reset. If set and clear coincide, set wins.
  - Pop when empty is ignored.
- Prescaler and sequencer never stall on the FIFO.

Test Plan:
- Sim params: NUM_SW=4, TICK_DIV=8, DEBOUNCE_MS=3, LONG_MS=5.
- Reset hold 3 cycles, inputs idle 1 -> o_switch=4'hF, o_evt_valid=0, o_overflow=0. Assert reset mid-count on ch1 -> no event, o_switch[1]=1.
- Ch2 driven 0 and held, i_evt_ready=1 -> o_switch[2] falls after 3rd qualifying scan. Single PRESS (id=2,type=0) valid 1 cycle. After 5 more ticks, one LONG (id=2,type=2), none afterwards. Release -> RELEASE after 3 ticks.
- Ch0 bounce pattern 0 for 2 ticks, 1 for 1 tick, repeated 4 times -> o_switch[0] stays 1, no events. Then held 0 -> PRESS.
- All 4 channels pressed on the same cycle, i_evt_ready=0 -> 4 PRESS queued in id order 0,1,2,3, o_overflow=0. 5th event (any release) -> dropped, o_overflow=1. Head unchanged while ready=0.
- FIFO full with i_evt_ready=1 at the moment of a push -> no drop, count stays 4, order preserved. i_ovf_clr pulse -> o_overflow=0. Coincident set and clear -> o_overflow=1.
- Randomised presses on all channels with random ready backpressure -> scoreboard order and count match a reference model; o_switch matches the model every cycle.
